// File: rtl/divider_pkg.sv
// Shared divider datapath definitions: default widths and FSM state encoding.
package divider_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/shift_restore_if.sv
// Start/done handshake and result bus between the quotient core and shift_restore.
interface shift_restore_if
    import divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] shift;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             overflow;

    modport master (
        output start, in_data, shift,
        input  busy, done, out, overflow
    );

    modport slave (
        input  start, in_data, shift,
        output busy, done, out, overflow
    );
endinterface

// File: rtl/shift_restore.sv
// Sequential left-shifter restoring divider result alignment, one bit per clock,
// flagging any set bit pushed out of the MSB.
//
// state | meaning
// IDLE  | waiting for start; result registers hold last value
// SHIFT | shifting out left once per clock while cnt counts down to 1
// DONE  | one-cycle result-valid pulse, then back to IDLE
module shift_restore
    import divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic            clk,
    input logic            rst_n,
    shift_restore_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] out_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.shift == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // SHIFT is only entered with cnt >= 1 and left at cnt == 1, so cnt never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ovf_q <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        out_q <= bus.in_data;
                        ovf_q <= 1'b0;
                        cnt   <= bus.shift;
                    end
                end
                ST_SHIFT: begin
                    out_q <= {out_q[WIDTH-2:0], 1'b0};
                    ovf_q <= ovf_q | out_q[WIDTH-1];
                    cnt   <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DONE);
    assign bus.out      = out_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_shift_restore.sv
// Scoreboard bench for shift_restore: directed vectors push expectations,
// a negedge monitor pops and checks them on every done pulse.
module tb_shift_restore;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   busy_run;

    typedef struct {
        logic [15:0] out;
        logic        ovf;
        int          sh;
        int          acc;
    } exp_t;

    exp_t sb[$];

    shift_restore_if #(.WIDTH(16), .CNT_W(4)) bus ();

    shift_restore #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expectation consumed per done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run <= 0;
        end else begin
            if (bus.busy) busy_run <= busy_run + 1;
            else          busy_run <= 0;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out", 32'(bus.out), 32'(e.out));
                    chk("overflow", 32'(bus.overflow), 32'(e.ovf));
                    chk("latency", 32'(cyc - e.acc), 32'(e.sh));
                    chk("busy_cycles", 32'(busy_run + 1), 32'(e.sh + 1));
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Drives start at a negedge while IDLE; returns at the negedge after the accept edge.
    task automatic issue(input logic [15:0] d, input logic [3:0] s,
                         input logic [15:0] eo, input logic eovf);
        exp_t e;
        wait_idle();
        bus.start   = 1'b1;
        bus.in_data = d;
        bus.shift   = s;
        e.out = eo;
        e.ovf = eovf;
        e.sh  = int'(s);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.in_data = 16'($urandom);
        bus.shift   = 4'($urandom);
    endtask

    initial begin
        logic [31:0] full;
        logic [15:0] sweep_d[2];
        bit          drained;

        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        busy_run    = 0;
        bus.start   = 1'b0;
        bus.in_data = '0;
        bus.shift   = '0;
        rst_n       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_overflow", 32'(bus.overflow), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        #3 rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        issue(16'h1234, 4'd0,  16'h1234, 1'b0);
        issue(16'h0003, 4'd5,  16'h0060, 1'b0);
        issue(16'h8001, 4'd1,  16'h0002, 1'b1);
        issue(16'h0001, 4'd15, 16'h8000, 1'b0);
        issue(16'hFFFF, 4'd4,  16'hFFF0, 1'b1);
        issue(16'h0F00, 4'd4,  16'hF000, 1'b0);
        issue(16'h0F00, 4'd5,  16'hE000, 1'b1);
        issue(16'h4000, 4'd1,  16'h8000, 1'b0);
        issue(16'h4000, 4'd2,  16'h0000, 1'b1);

        // start hammered through every busy cycle must be ignored.
        issue(16'h00FF, 4'd4, 16'h0FF0, 1'b0);
        for (int i = 0; i < 20 && bus.busy; i++) begin
            bus.start   = 1'b1;
            bus.in_data = 16'($urandom);
            bus.shift   = 4'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("held_result_out", 32'(bus.out), 32'h0FF0);
        issue(16'h0005, 4'd3, 16'h0028, 1'b0);

        // Asynchronous reset mid-SHIFT discards the operation.
        issue(16'hAAAA, 4'd8, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", 32'(bus.out), 32'h0);
        chk("midrst_overflow", 32'(bus.overflow), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        sb.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'h0);

        // Sweep every shift amount against a wide-shift reference.
        sweep_d[0] = 16'hA5C3;
        sweep_d[1] = 16'h0001;
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 16; s++) begin
                full = {16'h0, sweep_d[k]} << s;
                issue(sweep_d[k], 4'(s), full[15:0], |full[31:16]);
            end
        end

        drained = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) chk("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (5) @(negedge clk);
        chk("final_busy", 32'(bus.busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
